tlb_walker: RTL

Sequential translation stage between the processor's virtual address output and physical memory. It replaces the fixed combinational lookup table with a small fully-associative TLB. Misses are resolved by a hardware page-table walk over a request/acknowledge memory port. The processor presents a virtual address, stalls on `req_ready`, and consumes a one-cycle `rsp_valid` pulse carrying the physical address or a fault.

---
 rtl/tlb_walker.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/tlb_walker.sv
// tlb_walker: virtual-to-physical translation through a small
// fully-associative TLB. On a miss the block walks a single-level page
// table over a request/acknowledge port, then returns a one-cycle response.
//
// Ports:
//   Clock, Resetn        clock (rising edge), async active-high reset
//   req_valid/_vaddr/_write, req_ready   translation request handshake
//   flush                invalidate every TLB entry
//   rsp_valid/_paddr/_fault              one-cycle response pulse
//   pt_rd, pt_addr, pt_ack, pt_data      page-table read port
//   hit_count, miss_count                statistics
//
// Optional feature: define TLB_STATS_EN to build the saturating hit/miss
// counters; otherwise both statistics ports are tied to zero.
module tlb_walker #(
  parameter int unsigned ENTRIES = 4,
  parameter logic [15:0] PTBR    = 16'h0100
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req_valid,
  input  logic [15:0] req_vaddr,
  input  logic        req_write,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [15:0] rsp_paddr,
  output logic        rsp_fault,
  output logic        pt_rd,
  output logic [15:0] pt_addr,
  input  logic        pt_ack,
  input  logic [15:0] pt_data,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WALK, S_RESP} state_e;

  state_e             state_q;
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] wr_q;
  logic [7:0]         vpn_q [ENTRIES];
  logic [7:0]         ppn_q [ENTRIES];
  logic [15:0]        vaddr_q;
  logic               write_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      ptr_d;
  logic               rsp_valid_q;
  logic [15:0]        rsp_paddr_q;
  logic               rsp_fault_q;
  logic               pt_rd_q;
  logic [15:0]        pt_addr_q;

  logic               hit;
  logic [PW-1:0]      hit_idx;
  logic               lookup_hit;
  logic               hit_fault;
  logic               walk_fault;
  logic [PW-1:0]      victim;
  logic               victim_free;

  // PTE bits [13:8] carry no meaning for this block.
  logic unused_pte_bits;
  assign unused_pte_bits = ^pt_data[13:8];

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_paddr  = rsp_paddr_q;
  assign rsp_fault  = rsp_fault_q;
  assign pt_rd      = pt_rd_q;
  assign pt_addr    = pt_addr_q;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == vaddr_q[15:8])) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Lowest-index free entry wins; the round-robin pointer only serves a full TLB.
  always_comb begin
    victim      = ptr_q;
    victim_free = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!valid_q[i] && !victim_free) begin
        victim      = PW'(i);
        victim_free = 1'b1;
      end
    end
  end

  assign ptr_d      = (ptr_q == PW'(ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
  // A flush sampled during LOOKUP turns a would-be hit into a miss.
  assign lookup_hit = hit & ~flush;
  assign hit_fault  = write_q & ~wr_q[hit_idx];
  assign walk_fault = ~pt_data[15] | (write_q & ~pt_data[14]);

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      wr_q        <= '0;
      vaddr_q     <= '0;
      write_q     <= 1'b0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_paddr_q <= '0;
      rsp_fault_q <= 1'b0;
      pt_rd_q     <= 1'b0;
      pt_addr_q   <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        vpn_q[i] <= '0;
        ppn_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            vaddr_q <= req_vaddr;
            write_q <= req_write;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= hit_fault;
            rsp_paddr_q <= hit_fault ? '0 : {ppn_q[hit_idx], vaddr_q[7:0]};
            state_q     <= S_RESP;
          end else begin
            pt_rd_q   <= 1'b1;
            pt_addr_q <= PTBR + {8'h00, vaddr_q[15:8]};
            state_q   <= S_WALK;
          end
        end
        S_WALK: begin
          if (pt_ack) begin
            pt_rd_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= walk_fault;
            rsp_paddr_q <= walk_fault ? '0 : {pt_data[7:0], vaddr_q[7:0]};
            state_q     <= S_RESP;
            // Write-protected PTEs are still cached; a coincident flush suppresses the fill.
            if (pt_data[15] && !flush) begin
              valid_q[victim] <= 1'b1;
              wr_q[victim]    <= pt_data[14];
              vpn_q[victim]   <= vaddr_q[15:8];
              ppn_q[victim]   <= pt_data[7:0];
              if (!victim_free) begin
                ptr_q <= ptr_d;
              end
            end
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

`ifdef TLB_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
